// File: rtl/vec_bank_arbiter.sv
// vec_bank_arbiter: connects four vector lanes to four word-interleaved data
// banks. Each bank is granted to one lane per cycle in round-robin order.
// The bank's read data comes back one cycle later and is steered to the lane
// that issued the read.
module vec_bank_arbiter #(
   parameter int AW = 16,
   parameter int DW = 16,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      req,
   input  logic [3:0]      we,
   input  logic [4*AW-1:0] addr,
   input  logic [4*DW-1:0] wdata,
   output logic [3:0]      gnt,
   output logic [3:0]      rvalid,
   output logic [4*DW-1:0] rdata,
   output logic [4*AW-1:0] bank_raddr,
   output logic [3:0]      bank_wen,
   output logic [4*AW-1:0] bank_waddr,
   output logic [4*DW-1:0] bank_wdata,
   input  logic [4*DW-1:0] bank_rdata,
   output logic            conflict,
   output logic [CW-1:0]   conflict_cnt
);

   logic [3:0][1:0]    ptr_q, ptr_d;
   logic [3:0]         rd_own_v_q, rd_own_v_d;
   logic [3:0][1:0]    rd_own_q, rd_own_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [3:0][1:0]    lane_bank;
   logic [3:0][AW-1:0] lane_baddr;
   logic [3:0]         bank_hit;
   logic [3:0][1:0]    bank_win;
   logic [3:0]         lost;
   logic [3:0]         unused_addr_lsb;

   // Byte-address bit 0 has no meaning for word-wide banks.
   assign unused_addr_lsb = {addr[3*AW], addr[2*AW], addr[AW], addr[0]};

   // Saturating add of the per-cycle loser count (0..4) to the counter.
   function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] base,
                                             input logic [2:0]    inc);
      logic [CW:0] sum;
      sum = {1'b0, base} + {{(CW-2){1'b0}}, inc};
      if (sum[CW]) return '1;
      return sum[CW-1:0];
   endfunction

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   // Per-lane decode: target bank and the word address presented to it.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane_bank[i]  = addr[i*AW+1 +: 2];
         lane_baddr[i] = {2'b00, addr[i*AW+3 +: AW-3], 1'b0};
      end
   end

   // Round-robin pick per bank; scanning from ptr+3 down to ptr leaves the
   // first candidate in search order as the final winner.
   always_comb begin
      bank_hit = '0;
      bank_win = ptr_q;
      for (int b = 0; b < 4; b++) begin
         for (int k = 3; k >= 0; k--) begin
            if (rst_n && req[ptr_q[b] + 2'(k)] &&
                lane_bank[ptr_q[b] + 2'(k)] == 2'(b)) begin
               bank_hit[b] = 1'b1;
               bank_win[b] = ptr_q[b] + 2'(k);
            end
         end
      end
   end

   // Drive grants and bank ports from the winners; record read ownership.
   always_comb begin
      gnt        = '0;
      bank_wen   = '0;
      bank_raddr = '0;
      bank_waddr = '0;
      bank_wdata = '0;
      ptr_d      = ptr_q;
      rd_own_v_d = '0;
      rd_own_d   = rd_own_q;
      for (int b = 0; b < 4; b++) begin
         if (bank_hit[b]) begin
            gnt[bank_win[b]] = 1'b1;
            ptr_d[b]         = bank_win[b] + 2'd1;
            if (we[bank_win[b]]) begin
               bank_wen[b]              = 1'b1;
               bank_waddr[b*AW +: AW]   = lane_baddr[bank_win[b]];
               bank_wdata[b*DW +: DW]   = wdata[bank_win[b]*DW +: DW];
            end else begin
               bank_raddr[b*AW +: AW]   = lane_baddr[bank_win[b]];
               rd_own_v_d[b]            = 1'b1;
               rd_own_d[b]              = bank_win[b];
            end
         end
      end
   end

   // Lost requests feed the conflict flag and the saturating counter.
   always_comb begin
      lost         = req & ~gnt & {4{rst_n}};
      conflict     = |lost;
      cnt_d        = sat_add(cnt_q, popcount4(lost));
      conflict_cnt = cnt_q;
   end

   // Read return: each bank that was read last cycle answers its owner lane.
   always_comb begin
      rvalid = '0;
      rdata  = '0;
      for (int b = 0; b < 4; b++) begin
         if (rd_own_v_q[b]) begin
            rvalid[rd_own_q[b]]              = 1'b1;
            rdata[rd_own_q[b]*DW +: DW]      = bank_rdata[b*DW +: DW];
         end
      end
   end

   // State registers; reset also drops any read still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         rd_own_v_q <= '0;
         rd_own_q   <= '0;
         cnt_q      <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rd_own_v_q <= rd_own_v_d;
         rd_own_q   <= rd_own_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_vec_bank_arbiter.sv
// Bench for vec_bank_arbiter: directed scenarios followed by random traffic,
// all checked against a rule-level model of the arbiter and the banks.
module tb_vec_bank_arbiter;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req   = '0;
   logic [3:0]  we    = '0;
   logic [15:0] a [4];
   logic [15:0] d [4];
   logic [63:0] addr_bus, wdata_bus;

   logic [3:0]  gnt, rvalid, bank_wen;
   logic [63:0] rdata, bank_raddr, bank_waddr, bank_wdata;
   logic [63:0] bank_rdata;
   logic        conflict;
   logic [15:0] conflict_cnt;

   logic [3:0]  s_gnt, sat_unused_rvalid, sat_unused_wen;
   logic [63:0] sat_unused_rdata, sat_unused_raddr, sat_unused_waddr, sat_unused_wdata;
   logic        s_conflict;
   logic [3:0]  s_cnt;

   logic [15:0] mem [4][64];

   // model state
   int          mptr [4];
   int          mcnt16, mcnt4;
   logic [3:0]  prv;
   logic [15:0] prd [4];
   logic [15:0] smem [4][64];
   logic [3:0]  last_eg;
   logic [3:0]  obs_gnt, obs_rv;
   logic        obs_conf;
   logic [63:0] obs_rd;
   logic [15:0] obs_cnt;
   logic [3:0]  obs_scnt;
   int          checks   = 0;
   int          failures = 0;

   assign addr_bus  = {a[3], a[2], a[1], a[0]};
   assign wdata_bus = {d[3], d[2], d[1], d[0]};

   always #5 clk = ~clk;

   vec_bank_arbiter #(.AW(16), .DW(16), .CW(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr_bus),
      .wdata(wdata_bus), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .bank_raddr(bank_raddr), .bank_wen(bank_wen), .bank_waddr(bank_waddr),
      .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .conflict(conflict),
      .conflict_cnt(conflict_cnt)
   );

   vec_bank_arbiter #(.AW(16), .DW(16), .CW(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr_bus),
      .wdata(wdata_bus), .gnt(s_gnt), .rvalid(sat_unused_rvalid),
      .rdata(sat_unused_rdata), .bank_raddr(sat_unused_raddr),
      .bank_wen(sat_unused_wen), .bank_waddr(sat_unused_waddr),
      .bank_wdata(sat_unused_wdata), .bank_rdata(bank_rdata),
      .conflict(s_conflict), .conflict_cnt(s_cnt)
   );

   // four 64-word banks with one cycle of read latency
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (bank_wen[b]) mem[b][bank_waddr[b*16+1 +: 6]] <= bank_wdata[b*16 +: 16];
         bank_rdata[b*16 +: 16] <= mem[b][bank_raddr[b*16+1 +: 6]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 4; b++) mptr[b] = 0;
      mcnt16 = 0;
      mcnt4  = 0;
      prv    = '0;
   endtask

   task automatic chk_reset_outs();
      chk("rst_gnt", gnt, 0);
      chk("rst_sat_gnt", s_gnt, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_bank_wen", bank_wen, 0);
      chk("rst_bank_raddr", bank_raddr, 0);
      chk("rst_bank_waddr", bank_waddr, 0);
      chk("rst_bank_wdata", bank_wdata, 0);
      chk("rst_cnt16", conflict_cnt, 0);
      chk("rst_cnt4", s_cnt, 0);
   endtask

   // Called at a falling edge with inputs set; checks, then advances one cycle.
   task automatic cycle(input bit pulse_rst);
      logic [3:0]  eg, ewen, nrv;
      logic [63:0] era, ewa, ewd, erd;
      logic [15:0] word;
      int          win [4];
      int          i, w, lost;
      eg = '0; ewen = '0; era = '0; ewa = '0; ewd = '0; erd = '0;
      for (int b = 0; b < 4; b++) begin
         win[b] = -1;
         for (int k = 0; k < 4; k++) begin
            i = (mptr[b] + k) % 4;
            if (win[b] < 0 && req[i] && int'(a[i][2:1]) == b) win[b] = i;
         end
         if (win[b] >= 0) begin
            w    = win[b];
            word = {2'b00, a[w][15:3], 1'b0};
            eg[w] = 1'b1;
            if (we[w]) begin
               ewen[b]          = 1'b1;
               ewa[b*16 +: 16]  = word;
               ewd[b*16 +: 16]  = d[w];
            end else begin
               era[b*16 +: 16]  = word;
            end
         end
      end
      for (int l = 0; l < 4; l++) if (prv[l]) erd[l*16 +: 16] = prd[l];
      lost = $countones(req & ~eg);
      #1;
      chk("gnt", gnt, eg);
      chk("sat_gnt", s_gnt, eg);
      chk("conflict", conflict, lost != 0);
      chk("sat_conflict", s_conflict, lost != 0);
      chk("rvalid", rvalid, prv);
      chk("rdata", rdata, erd);
      chk("bank_wen", bank_wen, ewen);
      chk("bank_raddr", bank_raddr, era);
      chk("bank_waddr", bank_waddr, ewa);
      chk("bank_wdata", bank_wdata, ewd);
      chk("cnt16", conflict_cnt, mcnt16);
      chk("cnt4", s_cnt, mcnt4);
      obs_gnt = gnt; obs_rv = rvalid; obs_rd = rdata; obs_conf = conflict;
      obs_cnt = conflict_cnt; obs_scnt = s_cnt; last_eg = eg;
      if (pulse_rst) begin
         #1 rst_n = 1'b0;
         model_reset();
         #1;
         chk_reset_outs();
         @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         @(posedge clk);
         nrv = '0;
         for (int b = 0; b < 4; b++) begin
            if (win[b] >= 0) begin
               w       = win[b];
               mptr[b] = (w + 1) % 4;
               if (we[w]) smem[b][a[w][8:3]] = d[w];
               else begin
                  nrv[w] = 1'b1;
                  prd[w] = smem[b][a[w][8:3]];
               end
            end
         end
         prv    = nrv;
         mcnt16 = (mcnt16 + lost > 65535) ? 65535 : mcnt16 + lost;
         mcnt4  = (mcnt4 + lost > 15) ? 15 : mcnt4 + lost;
         @(negedge clk);
      end
   endtask

   // Requests are held high during reset to show they are ignored.
   task automatic do_reset();
      req = 4'hF;
      we  = 4'h0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_reset_outs();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req   = '0;
   endtask

   initial begin
      for (int l = 0; l < 4; l++) begin a[l] = '0; d[l] = '0; end
      model_reset();
      last_eg = '0;
      @(negedge clk);
      do_reset();

      // fill every bank word through the arbiter
      for (int w = 0; w < 64; w++) begin
         for (int b = 0; b < 4; b++) begin
            req[b] = 1'b1; we[b] = 1'b1;
            a[b] = 16'((w << 3) | (b << 1));
            d[b] = 16'hA000 + 16'(b * 256) + 16'(w);
         end
         cycle(0);
      end
      req = '0;
      cycle(0);

      // one read per bank, no contention
      do_reset();
      req = 4'hF; we = 4'h0;
      for (int l = 0; l < 4; l++) a[l] = 16'(l * 2);
      cycle(0);
      chk("t1_gnt", obs_gnt, 4'b1111);
      chk("t1_conflict", obs_conf, 0);
      req = '0;
      cycle(0);
      chk("t1_rvalid", obs_rv, 4'b1111);
      chk("t1_rdata", obs_rd, 64'hA300_A200_A100_A000);

      // lane 3 reads a word written just before
      do_reset();
      req = 4'b0001; we = 4'b0001; a[0] = 16'h0002; d[0] = 16'hBEEF;
      cycle(0);
      req = 4'b1000; we = 4'b0000; a[3] = 16'h0002;
      cycle(0);
      chk("t4_gnt", obs_gnt, 4'b1000);
      req = '0;
      cycle(0);
      chk("t4_rvalid", obs_rv, 4'b1000);
      chk("t4_rdata", obs_rd[63:48], 16'hBEEF);

      // all lanes write bank 0, each holds until granted
      do_reset();
      req = 4'hF; we = 4'hF;
      a[0] = 16'h00; a[1] = 16'h08; a[2] = 16'h10; a[3] = 16'h18;
      d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
      for (int c = 0; c < 4; c++) begin
         cycle(0);
         chk("t2_gnt", obs_gnt, 4'b0001 << c);
         req = req & ~last_eg;
      end
      req = '0;
      cycle(0);
      chk("t2_cnt", obs_cnt, 6);
      chk("t2_mem0", mem[0][0], 16'h1111);
      chk("t2_mem1", mem[0][1], 16'h2222);
      chk("t2_mem2", mem[0][2], 16'h3333);
      chk("t2_mem3", mem[0][3], 16'h4444);

      // lanes 0 and 1 keep reading bank 2
      do_reset();
      req = 4'b0011; we = 4'b0000; a[0] = 16'h04; a[1] = 16'h0C;
      for (int c = 0; c < 4; c++) begin
         cycle(0);
         chk("t3_gnt", obs_gnt, (c % 2 == 1) ? 4'b0010 : 4'b0001);
         chk("t3_cnt", obs_cnt, c);
      end

      // reset pulse drops an in-flight read and clears pointer and counter
      do_reset();
      req = 4'b1010; we = 4'b0000; a[1] = 16'h08; a[3] = 16'h18;
      cycle(0);
      req = 4'b0001; a[0] = 16'h00;
      cycle(1);
      req = 4'b0110; a[1] = 16'h08; a[2] = 16'h10;
      cycle(0);
      chk("t5_gnt", obs_gnt, 4'b0010);
      chk("t5_rvalid", obs_rv, 4'b0000);
      chk("t5_cnt", obs_cnt, 0);

      // four lanes hammer bank 3 for 8 cycles
      do_reset();
      req = 4'hF; we = 4'h0;
      a[0] = 16'h06; a[1] = 16'h0E; a[2] = 16'h16; a[3] = 16'h1E;
      for (int c = 0; c < 8; c++) cycle(0);
      req = '0;
      cycle(0);
      chk("t6_cnt4", obs_scnt, 15);
      chk("t6_cnt16", obs_cnt, 24);

      // random traffic; ungranted requests keep address and data stable
      do_reset();
      last_eg = '0;
      for (int n = 0; n < 400; n++) begin
         for (int l = 0; l < 4; l++) begin
            if (req[l] && !last_eg[l]) begin
               if ($urandom_range(0, 9) == 0) req[l] = 1'b0;
            end else begin
               req[l] = ($urandom_range(0, 3) != 0);
               we[l]  = 1'($urandom_range(0, 1));
               a[l]   = 16'($urandom_range(0, 511));
               d[l]   = 16'($urandom);
            end
         end
         cycle(0);
      end
      req = '0;
      cycle(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vec_bank_arbiter.md
# vec_bank_arbiter

Arbiter between the four vector lane pipelines and the four interleaved data memory banks. Each lane issues at most one scalar memory access per cycle. The block decodes the target bank from the address and grants each bank to one lane per cycle in round-robin order. It drives the bank ports and routes 1-cycle-latency read data back to the lane that issued the read. It sits between the execute stages of the lane pipelines and `mem_bank0..3`.

## Interface
- `AW`, 16, byte address width per lane
- `DW`, 16, data width per lane and per bank
- `CW`, 16, width of the conflict counter

Ports. Lane `i` owns slice `[i*AW +: AW]` / `[i*DW +: DW]`; bank `b` owns the same slicing.
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req`  in  4  lane access request, held until granted
- `we`  in  4  1 = write, 0 = read
- `addr`  in  4*AW  lane byte address; bit 0 ignored
- `wdata`  in  4*DW  lane write data
- `gnt`  out  4  access accepted this cycle (combinational)
- `rvalid`  out  4  read data for lane valid this cycle (registered)
- `rdata`  out  4*DW  read data per lane
- `bank_raddr`  out  4*AW  bank read address
- `bank_wen`  out  4  bank write enable
- `bank_waddr`  out  4*AW  bank write address
- `bank_wdata`  out  4*DW  bank write data
- `bank_rdata`  in  4*DW  bank read data, 1 cycle after `bank_raddr`
- `conflict`  out  1  some request lost arbitration this cycle
- `conflict_cnt`  out  CW  saturating count of lost requests

## Operation
- Bank select: `b = addr[2:1]`.
- Intra-bank word address: `bank_addr = {2'b00, addr[15:3], 1'b0}`. The bank indexes it with `[15:1]`.
- Per bank `b`, the candidate set is lanes with `req[i]` and `addr_i[2:1]==b`.
- Per-bank round-robin pointer `ptr[b]` (2 bits):
  - Search order is `ptr, ptr+1, ptr+2, ptr+3` mod 4; the first candidate wins.
  - On a grant, `ptr[b] <= winner+1` mod 4.
  - With no candidates, `ptr[b]` holds.
- `gnt[i]` = 1 iff lane `i` won its bank. At most one grant per lane per cycle.
- Granted write to bank `b`:
  - `bank_wen[b]=1`.
  - `bank_waddr[b]` and `bank_wdata[b]` taken from the winner.
  - `bank_raddr[b]=0`.
- Granted read to bank `b`:
  - `bank_raddr[b]` taken from the winner; `bank_wen[b]=0`.
  - Register `rd_own_v[b]=1` and `rd_own[b]=winner`.
- Idle bank: `bank_wen=0`; all bank address and data outputs are 0.
- Read return: `rvalid[i]` = OR over banks of `rd_own_v[b] && rd_own[b]==i`.
  - `rdata` slice `i` = `bank_rdata[b]` of that bank when valid, else 0.
  - Only one bank can return to a lane, because only one grant per lane per cycle.
- Conflict:
  - `conflict = |(req & ~gnt)`.
  - `conflict_cnt += popcount(req & ~gnt)` each cycle, saturating at `2^CW-1`.
- Lanes must hold `we`, `addr` and `wdata` stable while `req` is high and ungranted. Deasserting `req` before grant withdraws the request; nothing is recorded.

## Timing
- Grant is combinational, in the same cycle as `req`. Writes commit at the rising edge ending the grant cycle.
- Read latency: `rvalid` and `rdata` appear exactly 1 cycle after the grant cycle.
- Back-to-back grants to the same bank every cycle are supported; no bubbles.
- Read and write to the same address by different lanes in one cycle: only one is granted, per round-robin. The loser retries next cycle and sees the committed write.
- Reset (`rst_n` low, asynchronous):
  - `ptr[*]=0`, `rd_own_v=0`, `rvalid=0`, `conflict_cnt=0`.
  - While low: `gnt=0`, `bank_wen=0`, `conflict=0`, and all address/data outputs are 0.
  - A read granted in the cycle before reset asserts is dropped; no `rvalid` follows.
- Reset release: arbitration resumes on the first cycle with `rst_n` high.

## Test plan
- Lanes 0..3 read addresses `0x0000`, `0x0002`, `0x0004`, `0x0006` in one cycle -> `gnt=4'b1111`, `conflict=0`. Next cycle `rvalid=4'b1111` and each lane gets its own bank's word 0.
- All lanes write bank 0 (addresses `0x00`, `0x08`, `0x10`, `0x18`, data `0x1111..0x4444`), held until granted -> grants to lane 0, 1, 2, 3 on consecutive cycles. `conflict_cnt=6`. Bank 0 words 0..3 hold `0x1111..0x4444`.
- Lanes 0 and 1 continuously read bank 2 after reset -> grant sequence 0, 1, 0, 1. `conflict_cnt` increments by 1 per cycle.
- Bank 1 word 0 = `0xBEEF`; lane 3 reads `0x0002`, no other requests -> `gnt=4'b1000`. Next cycle `rvalid=4'b1000` and lane 3 `rdata=0xBEEF`.
- Lane 0 granted a read, `rst_n` pulsed low before the next edge -> `rvalid` stays 0, `ptr` and `conflict_cnt` cleared. A bank 0 request right after release grants the lowest-indexed requesting lane.
- With `CW=4`, four lanes hold requests to one bank for 8 cycles -> `conflict_cnt` saturates at 15 and holds.
